// File: rtl/uart_mmio.sv
`timescale 1ns/1ps
// uart_mmio: memory-mapped UART with TX/RX FIFOs, a runtime baud divisor,
// sticky error flags and a level interrupt.
//
// Ports:
//   clk, rst   - system clock (rising edge), async active-high reset
//   addr       - register offset, addr[3:2] selects DATA/STATUS/BAUD_DIV/CTRL
//   write_en   - single-cycle register write strobe
//   read_en    - single-cycle register read strobe (DATA read pops RX FIFO)
//   wdata      - write data
//   rdata      - combinational read data for the current addr
//   rx         - asynchronous serial input
//   tx         - serial output, idles high
//   uart_busy  - TX FIFO full, kept for the MMU busy-polling path
//   irq        - (rx_irq_en & rx_valid) | (tx_irq_en & tx_empty)
module uart_mmio #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        uart_busy,
  output logic        irq
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUD);
  localparam logic [TX_AW:0] TX_ONE = 1;
  localparam logic [RX_AW:0] RX_ONE = 1;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_BAUD = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------------------------------------------------------------
  // Register access decode
  // ---------------------------------------------------------------------
  logic [1:0] sel;
  logic       wr_data, wr_stat, wr_baud, wr_ctrl;
  logic       rx_pop;
  logic       rx_valid;

  assign sel     = addr[3:2];
  assign wr_data = write_en & (sel == A_DATA);
  assign wr_stat = write_en & (sel == A_STAT);
  assign wr_baud = write_en & (sel == A_BAUD);
  assign wr_ctrl = write_en & (sel == A_CTRL);
  // A simultaneous write wins; the read's pop side effect is suppressed.
  assign rx_pop  = read_en & ~write_en & (sel == A_DATA) & rx_valid;

  // Offset low bits and upper write-data bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = &{1'b0, addr[1:0], wdata[31:16]};

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  logic [15:0] baud_div;
  logic [1:0]  ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_div <= DIV_RST;
      ctrl     <= 2'b00;
    end else begin
      if (wr_baud) baud_div <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
      if (wr_ctrl) ctrl <= wdata[1:0];
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO (extra pointer bit separates full from empty on wrap)
  // ---------------------------------------------------------------------
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wp, tx_rp;
  logic           tx_full, tx_empty, tx_push, tx_pop;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) &&
                    (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);
  // Fullness is the pre-edge value: a pop on the same edge does not make room.
  assign tx_push  = wr_data & ~tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_ONE;
      if (tx_pop)  tx_rp <= tx_rp + TX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= wdata[7:0];
  end

  // ---------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------
  state_t      tx_st;
  logic [15:0] tx_div, tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_last;

  assign tx_last = (tx_cnt == tx_div - 16'd1);
  // Loading straight from the end of STOP keeps back-to-back frames gapless.
  assign tx_pop  = ~tx_empty & ((tx_st == S_IDLE) | ((tx_st == S_STOP) & tx_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st  <= S_IDLE;
      tx     <= 1'b1;
      tx_div <= DIV_RST;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else if (tx_pop) begin
      // Divisor is captured per frame; BAUD_DIV writes apply to the next one.
      tx_st  <= S_START;
      tx     <= 1'b0;
      tx_sh  <= tx_mem[tx_rp[TX_AW-1:0]];
      tx_div <= baud_div;
      tx_cnt <= '0;
    end else begin
      case (tx_st)
        S_IDLE: tx <= 1'b1;
        S_START: begin
          if (tx_last) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx     <= tx_sh[0];
            tx_st  <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx    <= 1'b1;
              tx_st <= S_STOP;
            end else begin
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx     <= tx_sh[1];
              tx_bit <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin // S_STOP
          if (tx_last) begin
            tx_cnt <= '0;
            tx_st  <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX synchroniser plus one history flop for falling-edge detection
  // ---------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wp, rx_rp;
  logic           rx_full, rx_empty, rx_push;
  logic [7:0]     rx_sh;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_valid = ~rx_empty;
  assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) &&
                    (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_ONE;
      if (rx_pop)  rx_rp <= rx_rp + RX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= rx_sh;
  end

  // ---------------------------------------------------------------------
  // RX FSM: samples at mid-bit, counted from the synchronised falling edge
  // ---------------------------------------------------------------------
  state_t      rx_st;
  logic [15:0] rx_div, rx_cnt;
  logic [2:0]  rx_bit;
  logic        rx_bit_end, rx_half, rx_stop_smp;
  logic        set_ovr, set_fe;

  assign rx_bit_end  = (rx_cnt == rx_div - 16'd1);
  // Edge detect costs one cycle, so mid-start lands one count early.
  assign rx_half     = (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1);
  assign rx_stop_smp = (rx_st == S_STOP) & rx_bit_end;
  // A same-edge pop frees the slot first, so a full FIFO still accepts.
  assign rx_push     = rx_stop_smp & rx_s2 & (~rx_full | rx_pop);
  assign set_ovr     = rx_stop_smp & rx_s2 & rx_full & ~rx_pop;
  assign set_fe      = rx_stop_smp & ~rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st  <= S_IDLE;
      rx_div <= DIV_RST;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      case (rx_st)
        S_IDLE: begin
          if (rx_prev & ~rx_s2) begin
            rx_div <= baud_div;
            rx_cnt <= '0;
            rx_st  <= S_START;
          end
        end
        S_START: begin
          if (rx_half) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            // Line back high at mid-start: treat as a glitch.
            rx_st  <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_st <= S_STOP;
            else                rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: begin // S_STOP
          if (rx_bit_end) begin
            rx_cnt <= '0;
            rx_st  <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error flags: W1C, a new event on the clearing edge wins
  // ---------------------------------------------------------------------
  logic overrun, frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (overrun   & ~(wr_stat & wdata[5])) | set_ovr;
      frame_err <= (frame_err & ~(wr_stat & wdata[6])) | set_fe;
    end
  end

  // ---------------------------------------------------------------------
  // Read mux and status outputs
  // ---------------------------------------------------------------------
  logic tx_active;
  assign tx_active = (tx_st != S_IDLE) | ~tx_empty;

  always_comb begin
    rdata = '0;
    case (sel)
      A_DATA:  if (rx_valid) rdata[7:0] = rx_mem[rx_rp[RX_AW-1:0]];
      A_STAT:  rdata[6:0] = {frame_err, overrun, rx_full, rx_valid,
                             tx_active, tx_empty, tx_full};
      A_BAUD:  rdata[15:0] = baud_div;
      default: rdata[1:0] = ctrl;
    endcase
  end

  assign uart_busy = tx_full;
  assign irq       = (ctrl[0] & rx_valid) | (ctrl[1] & tx_empty);

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped, parametrised UART that succeeds the single-byte, TX-only uart_tx. It adds a TX FIFO, a receiver with its own RX FIFO, a runtime baud divisor, sticky error flags and an interrupt output. It sits behind the MMU in the UART window, with register offsets decoded from addr[3:2]. It also exports uart_busy so the existing MMU busy-polling path keeps working unchanged.

Parameters:
CLK_FREQ, 100000000, system clock in Hz.
BAUD, 115200, reset baud rate; reset divisor DIV_RST = CLK_FREQ/BAUD (868).
TX_DEPTH, 16, TX FIFO entries; power of 2, at least 2.
RX_DEPTH, 16, RX FIFO entries; power of 2, at least 2.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
addr  in  4  register offset; addr[3:2] selects the register, addr[1:0] is ignored
write_en  in  1  register write strobe, one cycle per access
read_en  in  1  register read strobe; has side effects on DATA
wdata  in  32  write data
rdata  out  32  combinational read data for the current addr
rx  in  1  serial input, asynchronous to clk
tx  out  1  serial output
uart_busy  out  1  equals TX FIFO full
irq  out  1  level interrupt

Behaviour:
- Register map:
  - 0x0 DATA: write pushes wdata[7:0] into the TX FIFO. Read returns {24'b0, RX head} and pops the RX FIFO on that edge. If the RX FIFO is empty, a DATA read returns 0 and does not pop.
  - 0x4 STATUS: read-only bits [0] tx_full, [1] tx_empty, [2] tx_active (FSM not IDLE or FIFO non-empty), [3] rx_valid, [4] rx_full. Sticky bits [5] overrun and [6] frame_err clear when written with 1 (W1C). Bits [31:7] read 0.
  - 0x8 BAUD_DIV: [15:0] clocks per bit. Writes below 4 are clamped to 4.
  - 0xC CTRL: [0] rx_irq_en, [1] tx_irq_en. Other bits read 0.
- If write_en and read_en are asserted together: the write executes and the read side effect (RX pop) is suppressed.
- A DATA write while tx_full is dropped silently. Fullness is the value registered before the edge, even if the TX FSM pops in the same cycle.
- Reset values: tx=1, uart_busy=0, irq=0, both FIFOs empty, STATUS=0x2, BAUD_DIV=DIV_RST, CTRL=0, both FSMs in IDLE.
- Asserting rst mid-frame forces tx=1 immediately and discards any partial frame.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE with FIFO non-empty: pop the byte, latch the divisor and enter START. The divisor is latched per frame, so BAUD_DIV writes take effect at the next frame.
  - START: tx=0 for div clocks.
  - DATA: 8 bits LSB first, div clocks each.
  - STOP: tx=1 for div clocks, then return to IDLE. Back-to-back frames have no extra idle clocks.
- RX path:
  - rx passes through a 2-flop synchroniser, which adds 2 cycles of latency.
  - IDLE: a falling edge latches the divisor and enters START.
  - START: at div/2, if the sampled line is 1, return to IDLE (glitch reject); otherwise enter DATA.
  - DATA: sample 8 bits, one every div clocks, each at mid-bit, LSB first.
  - STOP: sample at mid-bit.
    - Sample = 1 and RX FIFO not full: push the byte.
    - Sample = 1 and RX FIFO full: drop the byte and set overrun.
    - Sample = 0: drop the byte and set frame_err.
    - Return to IDLE immediately after the stop sample.
- If a push and a pop hit the RX FIFO on the same edge: both occur and the count is unchanged. This holds when full, because the pop happens first.
- FIFO pointers use log2(DEPTH)+1 bits, so full and empty are distinguished on wrap-around.
- irq = (rx_irq_en & rx_valid) | (tx_irq_en & tx_empty). It is a level output, not pulsed.

Test Plan:
- Reset check: after rst, tx=1, STATUS=0x2, BAUD_DIV reads 868, irq=0.
- TX single byte: write BAUD_DIV=8, then DATA=0xA5 → tx shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 8 clocks, 80 clocks total. tx_empty=1 and tx_active=0 afterwards.
- TX full: with DIV=8, write 17 bytes 0x00..0x10 → uart_busy=1 after the 16th. The 17th is dropped if the FSM has not yet popped; the serial output matches the accepted bytes in order.
- RX loopback: drive rx with 0x3C at DIV=8 → rx_valid=1 and irq=1 with rx_irq_en set. A DATA read returns 0x3C, the second read returns 0, and rx_valid=0.
- RX errors: 17 frames with no reads → overrun=1 and 16 bytes are retained. A frame with stop=0 → frame_err=1. Writing STATUS=0x60 clears both.
- Reset mid-frame plus glitch: assert rst during TX bit 3 → tx=1 at once and TX FIFO empty. A 2-clock low pulse on rx at DIV=8 → no byte pushed and no flags set.
